sr_latch_driver: RTL and testbench
==================================

Name: sr_latch_driver

Overview:
- Synchronous command sequencer that drives the s, r and en inputs of a gated SR latch.
- Each accepted command becomes a safe pulse sequence: data setup, enable pulse, hold, settle. The latch outputs q/qb are then read back and checked against the expected value.
- The driver never presents s=r=1 while en is high.
- Sits between a control FSM or test controller and any sr_gated-style latch instance.

Parameters:
- PULSE_CYC, 2, number of clk cycles en is held high (legal range 1..15)
- SETTLE_CYC, 2, number of clk cycles waited after en falls before q/qb are sampled (legal range 1..15)

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous active-high reset
- cmd_valid  input  1  command request
- cmd_ready  output  1  driver idle; command accepted when cmd_valid & cmd_ready
- cmd_op  input  2  00 HOLD, 01 RESET, 10 SET, 11 ILLEGAL
- s  output  1  latch set input
- r  output  1  latch reset input
- en  output  1  latch gate enable
- q_in  input  1  latch q readback
- qb_in  input  1  latch qb readback
- done  output  1  one-cycle pulse when a command completes (including rejected ones)
- err  output  1  valid with done: 1 = check failed or command illegal
- q_exp  output  1  expected q for the last completed command; valid with done

Behaviour:
- Reset (synchronous, rst=1 at a rising edge):
  - state=IDLE; s=0, r=0, en=0, done=0, err=0, q_exp=0, cmd_ready=1.
  - The stored previous-q register is cleared to 0.
- All outputs are registered. cmd_ready=1 only in IDLE.
- FSM states: IDLE, SETUP, PULSE, HOLD, SETTLE, CHECK.
- IDLE:
  - On accept with op in {00,01,10}: latch op into op_r, snapshot q_in into q_prev, go to SETUP.
    - s/r are driven from op: SET -> s=1,r=0; RESET -> s=0,r=1; HOLD -> s=0,r=0.
    - en=0.
  - On accept with op=11: no latch activity (s=r=en=0). Next cycle done=1, err=1, q_exp unchanged, stay IDLE.
- SETUP: one cycle with s/r stable and en=0. Next state PULSE with en=1; load counter=PULSE_CYC-1.
- PULSE:
  - en=1 and s/r constant for exactly PULSE_CYC cycles.
  - When counter=0: en=0 and go to HOLD.
- HOLD: one cycle with en=0 and s/r still held (hold time). Then s=r=0; load counter=SETTLE_CYC-1; go to SETTLE.
- SETTLE: wait until counter=0, then go to CHECK.
- CHECK (one cycle):
  - Expected q: SET->1, RESET->0, HOLD->q_prev.
  - err=1 if q_in != expected or qb_in != ~expected (this includes q_in==qb_in).
  - done=1, q_exp=expected, go to IDLE. cmd_ready returns 1 on the following cycle.
- Latency from accept edge to done for a legal op: 1 (SETUP) + PULSE_CYC + 1 (HOLD) + SETTLE_CYC + 1 (CHECK) cycles. With defaults this is 7.
- Invariant: en=1 implies {s,r} != 11, for every cycle including around reset.
- Reset mid-operation: at the reset edge en, s and r go to 0 immediately, no done is produced, and the FSM returns to IDLE.
- cmd_valid while busy: ignored, cmd_ready=0; the requester must hold cmd_valid.
- Counter is 4 bits. A PULSE_CYC or SETTLE_CYC of 0 is illegal; an elaboration-time check flags it.

Decomposition:
- Shared package sr_drv_pkg holds:
  - op encodings OP_HOLD, OP_RESET, OP_SET, OP_ILLEGAL;
  - state encoding constants;
  - the expected-q function.
- One natural sub-module, sr_drv_cnt: 4-bit loadable down-counter with a zero flag, reused for both the PULSE and SETTLE phases.
- The bench instantiates sr_latch_driver with sr_gated connected to s/r/en/q/qb.

Test Plan:
- rst, then SET (op=10) with defaults -> s=1,r=0 through SETUP/PULSE/HOLD; en high exactly 2 cycles; done 7 cycles after accept; q_exp=1, err=0, q_in=1, qb_in=0.
- SET, then RESET (op=01) -> second done has q_exp=0, err=0; latch q=0, qb=1.
- SET, then HOLD (op=00) -> en pulses with s=r=0; q_exp=1 (q_prev), err=0.
- op=11 in IDLE -> en never rises; done=1, err=1 one cycle after accept; cmd_ready stays 1 afterwards.
- Force q_in=qb_in=1 during CHECK of a SET command -> done=1, err=1.
- Assert rst while in PULSE of a SET command -> next edge en=0, s=0, r=0, cmd_ready=1, no done pulse. Across all tests, an assertion confirms en & s & r is never 1.

Source files
------------

// File: rtl/sr_drv_pkg.sv
// Shared definitions for the gated SR latch driver.
//   op_e        : command encodings carried on cmd_op
//   state_e     : sequencer states (IDLE, SETUP, PULSE, HOLD, SETTLE, CHECK)
//   CNT_W       : width of the phase counter
//   expected_q(): value the latch q must show after a given command
package sr_drv_pkg;

  typedef enum logic [1:0] {
    OP_HOLD    = 2'b00,
    OP_RESET   = 2'b01,
    OP_SET     = 2'b10,
    OP_ILLEGAL = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_PULSE  = 3'd2,
    ST_HOLD   = 3'd3,
    ST_SETTLE = 3'd4,
    ST_CHECK  = 3'd5
  } state_e;

  localparam int CNT_W = 4;

  // HOLD leaves the latch untouched, so it must still show the value
  // that was read back when the command was accepted.
  function automatic logic expected_q(op_e op, logic q_prev);
    case (op)
      OP_SET:   expected_q = 1'b1;
      OP_RESET: expected_q = 1'b0;
      default:  expected_q = q_prev;
    endcase
  endfunction

endpackage

// File: rtl/sr_drv_cnt.sv
// Loadable down-counter shared by the PULSE and SETTLE phases.
//   clk, rst  : clock, synchronous active-high reset
//   load      : load load_val (has priority over dec)
//   load_val  : value to load
//   dec       : decrement by one, saturating at zero
//   zero      : count is zero
module sr_drv_cnt
  import sr_drv_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/sr_latch_driver.sv
// Command sequencer driving the s/r/en inputs of a gated SR latch.
// Every legal command becomes: SETUP (data stable, en=0), PULSE (en=1 for
// PULSE_CYC cycles), HOLD (en=0, data held), SETTLE (data cleared, wait
// SETTLE_CYC cycles), CHECK (compare q/qb readback with the expected value).
//   clk, rst            : clock, synchronous active-high reset
//   cmd_valid/cmd_ready : command handshake
//   cmd_op              : 00 HOLD, 01 RESET, 10 SET, 11 ILLEGAL
//   s, r, en            : latch drive (registered)
//   q_in, qb_in         : latch readback
//   done, err, q_exp    : completion pulse, check result, expected q
//
// Handshake: a command is taken on a rising edge where cmd_valid and
// cmd_ready are both 1. cmd_ready is 1 only in IDLE; while busy the request
// is ignored and the requester keeps cmd_valid asserted.
module sr_latch_driver
  import sr_drv_pkg::*;
#(
  parameter int unsigned PULSE_CYC  = 2,
  parameter int unsigned SETTLE_CYC = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  output logic       s,
  output logic       r,
  output logic       en,
  input  logic       q_in,
  input  logic       qb_in,
  output logic       done,
  output logic       err,
  output logic       q_exp
);

  if (PULSE_CYC < 1 || PULSE_CYC > 15) begin : g_bad_pulse
    $error("sr_latch_driver: PULSE_CYC must be in 1..15");
  end
  if (SETTLE_CYC < 1 || SETTLE_CYC > 15) begin : g_bad_settle
    $error("sr_latch_driver: SETTLE_CYC must be in 1..15");
  end

  localparam logic [CNT_W-1:0] PULSE_LOAD  = CNT_W'(PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYC - 1);

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic             q_prev_q, q_prev_d;
  logic             ill_q, ill_d;
  logic             s_d, r_d, en_d, done_d, err_d, q_exp_d;
  logic             cnt_load, cnt_dec, cnt_zero;
  logic [CNT_W-1:0] cnt_val;
  logic             exp_q;

  sr_drv_cnt u_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (cnt_val),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  assign exp_q = expected_q(op_q, q_prev_q);

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    q_prev_d = q_prev_q;
    ill_d    = 1'b0;
    s_d      = s;
    r_d      = r;
    en_d     = 1'b0;
    // An illegal command is reported one cycle after it is taken.
    done_d   = ill_q;
    err_d    = ill_q;
    q_exp_d  = q_exp;
    cnt_load = 1'b0;
    cnt_val  = '0;
    cnt_dec  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        s_d = 1'b0;
        r_d = 1'b0;
        if (cmd_valid && cmd_ready) begin
          if (op_e'(cmd_op) == OP_ILLEGAL) begin
            ill_d = 1'b1;
          end else begin
            op_d     = op_e'(cmd_op);
            q_prev_d = q_in;
            // At most one of s/r can be set here, so en never sees s=r=1.
            s_d      = (op_e'(cmd_op) == OP_SET);
            r_d      = (op_e'(cmd_op) == OP_RESET);
            state_d  = ST_SETUP;
          end
        end
      end
      ST_SETUP: begin
        en_d     = 1'b1;
        cnt_load = 1'b1;
        cnt_val  = PULSE_LOAD;
        state_d  = ST_PULSE;
      end
      ST_PULSE: begin
        if (cnt_zero) begin
          state_d = ST_HOLD;
        end else begin
          en_d    = 1'b1;
          cnt_dec = 1'b1;
        end
      end
      ST_HOLD: begin
        s_d      = 1'b0;
        r_d      = 1'b0;
        cnt_load = 1'b1;
        cnt_val  = SETTLE_LOAD;
        state_d  = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (cnt_zero) begin
          state_d = ST_CHECK;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_CHECK: begin
        done_d  = 1'b1;
        // Also catches q_in == qb_in, which no valid latch state produces.
        err_d   = (q_in != exp_q) || (qb_in != ~exp_q);
        q_exp_d = exp_q;
        state_d = ST_IDLE;
      end
      default: begin
        s_d     = 1'b0;
        r_d     = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      op_q      <= OP_HOLD;
      q_prev_q  <= 1'b0;
      ill_q     <= 1'b0;
      s         <= 1'b0;
      r         <= 1'b0;
      en        <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      q_exp     <= 1'b0;
      cmd_ready <= 1'b1;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      q_prev_q  <= q_prev_d;
      ill_q     <= ill_d;
      s         <= s_d;
      r         <= r_d;
      en        <= en_d;
      done      <= done_d;
      err       <= err_d;
      q_exp     <= q_exp_d;
      cmd_ready <= (state_d == ST_IDLE);
    end
  end

endmodule

// File: tb/tb_sr_latch_driver.sv
module tb_sr_latch_driver;

  localparam int P   = 2;
  localparam int S   = 2;
  localparam int LAT = P + S + 3;

  logic       clk;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic       s, r, en;
  logic       q_in, qb_in;
  logic       done, err, q_exp;

  int checks = 0;
  int fails  = 0;

  // Behavioural gated SR latch, with a readback fault that forces q=qb=1.
  logic lq;
  bit   fault = 0;
  bit   armed = 0;

  // Reference state: latch contents and last reported q_exp.
  logic model_q;
  logic last_qexp;

  sr_latch_driver #(.PULSE_CYC(P), .SETTLE_CYC(S)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .s         (s),
    .r         (r),
    .en        (en),
    .q_in      (q_in),
    .qb_in     (qb_in),
    .done      (done),
    .err       (err),
    .q_exp     (q_exp)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial lq = 1'($urandom_range(0, 1));

  always @(s or r or en) begin
    if (en === 1'b1) begin
      if (s === 1'b1 && r === 1'b0) lq = 1'b1;
      else if (r === 1'b1 && s === 1'b0) lq = 1'b0;
    end
  end

  assign q_in  = fault ? 1'b1 : lq;
  assign qb_in = fault ? 1'b1 : ~lq;

  // Latch safety: en must never be high together with s and r.
  always @(negedge clk) begin
    if (armed) begin
      checks++;
      if ((en & s & r) !== 1'b0) begin
        fails++;
        $display("FAIL sr_invariant: en=%b s=%b r=%b, required en&s&r=0", en, s, r);
      end
    end
  end

  // ---------------- driver ----------------
  // Called at a point away from the rising edge; returns at the negedge on
  // which done was seen (or after the cycle budget, with lat = -1).
  task automatic run_cmd(input logic [1:0] op, input bit inj,
                         output int lat, output bit ready_ok, output bit sr_ok,
                         output int en_cyc, output logic err_o, output logic qexp_o);
    logic exp_s, exp_r;
    exp_s    = (op == 2'b10);
    exp_r    = (op == 2'b01);
    ready_ok = (cmd_ready === 1'b1);
    sr_ok    = 1'b1;
    en_cyc   = 0;
    lat      = -1;
    err_o    = 1'bx;
    qexp_o   = 1'bx;
    cmd_valid = 1'b1;
    cmd_op    = op;
    @(posedge clk);
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (k == 0) begin
        cmd_valid = 1'b0;
        cmd_op    = 2'($urandom_range(0, 3));
        fault     = inj;
      end
      if (en === 1'b1) begin
        en_cyc++;
        if (s !== exp_s || r !== exp_r) sr_ok = 1'b0;
      end
      if (done === 1'b1) begin
        lat    = k;
        err_o  = err;
        qexp_o = q_exp;
        break;
      end
    end
    fault = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_op = 2'b00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    armed = 1;
    checks++;
    if ({cmd_ready, s, r, en, done, err, q_exp} !== 7'b1000000) begin
      fails++;
      $display("FAIL reset_outputs: got {rdy,s,r,en,done,err,q_exp}=%b, required 1000000",
               {cmd_ready, s, r, en, done, err, q_exp});
    end
    rst = 1'b0;
    last_qexp = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_set();
    int lat, en_cyc; bit rdy, srok; logic e, qx;
    run_cmd(2'b10, 0, lat, rdy, srok, en_cyc, e, qx);
    model_q = 1'b1; last_qexp = 1'b1;
    checks++; if (!rdy) begin fails++; $display("FAIL set_ready: cmd_ready=0, required 1"); end
    checks++; if (lat != LAT) begin fails++; $display("FAIL set_latency: got %0d, required %0d", lat, LAT); end
    checks++; if (en_cyc != P) begin fails++; $display("FAIL set_en_width: got %0d, required %0d", en_cyc, P); end
    checks++; if (!srok) begin fails++; $display("FAIL set_sr_during_en: s/r not 1/0 while en high"); end
    checks++; if (e !== 1'b0 || qx !== 1'b1) begin fails++; $display("FAIL set_result: err=%b q_exp=%b, required 0/1", e, qx); end
    checks++; if (q_in !== 1'b1 || qb_in !== 1'b0) begin fails++; $display("FAIL set_latch: q=%b qb=%b, required 1/0", q_in, qb_in); end
  endtask

  task automatic test_set_reset();
    int lat, en_cyc; bit rdy, srok; logic e, qx;
    run_cmd(2'b10, 0, lat, rdy, srok, en_cyc, e, qx);
    run_cmd(2'b01, 0, lat, rdy, srok, en_cyc, e, qx);
    model_q = 1'b0; last_qexp = 1'b0;
    checks++; if (lat != LAT || !srok || en_cyc != P) begin fails++; $display("FAIL reset_op_timing: lat=%0d en_cyc=%0d sr_ok=%0d, required %0d/%0d/1", lat, en_cyc, srok, LAT, P); end
    checks++; if (e !== 1'b0 || qx !== 1'b0) begin fails++; $display("FAIL reset_op_result: err=%b q_exp=%b, required 0/0", e, qx); end
    checks++; if (q_in !== 1'b0 || qb_in !== 1'b1) begin fails++; $display("FAIL reset_op_latch: q=%b qb=%b, required 0/1", q_in, qb_in); end
  endtask

  task automatic test_set_hold();
    int lat, en_cyc; bit rdy, srok; logic e, qx;
    run_cmd(2'b10, 0, lat, rdy, srok, en_cyc, e, qx);
    run_cmd(2'b00, 0, lat, rdy, srok, en_cyc, e, qx);
    model_q = 1'b1; last_qexp = 1'b1;
    checks++; if (en_cyc != P || !srok) begin fails++; $display("FAIL hold_pulse: en_cyc=%0d sr_ok=%0d, required %0d with s=r=0", en_cyc, srok, P); end
    checks++; if (e !== 1'b0 || qx !== 1'b1 || lat != LAT) begin fails++; $display("FAIL hold_result: err=%b q_exp=%b lat=%0d, required 0/1/%0d", e, qx, lat, LAT); end
  endtask

  task automatic test_illegal();
    int lat, en_cyc; bit rdy, srok; logic e, qx;
    run_cmd(2'b11, 0, lat, rdy, srok, en_cyc, e, qx);
    checks++; if (en_cyc != 0) begin fails++; $display("FAIL illegal_en: en high %0d cycles, required 0", en_cyc); end
    checks++; if (lat != 1) begin fails++; $display("FAIL illegal_latency: got %0d, required 1", lat); end
    checks++; if (e !== 1'b1 || qx !== last_qexp) begin fails++; $display("FAIL illegal_result: err=%b q_exp=%b, required 1/%b", e, qx, last_qexp); end
    @(negedge clk);
    checks++; if (cmd_ready !== 1'b1 || done !== 1'b0) begin fails++; $display("FAIL illegal_after: ready=%b done=%b, required 1/0", cmd_ready, done); end
  endtask

  task automatic test_fault_check();
    int lat, en_cyc; bit rdy, srok; logic e, qx;
    run_cmd(2'b10, 1, lat, rdy, srok, en_cyc, e, qx);
    model_q = 1'b1; last_qexp = 1'b1;
    checks++; if (lat != LAT || e !== 1'b1 || qx !== 1'b1) begin fails++; $display("FAIL fault_check: lat=%0d err=%b q_exp=%b, required %0d/1/1", lat, e, qx, LAT); end
  endtask

  task automatic test_back_to_back();
    logic [1:0] ops [3];
    int lat, en_cyc; bit rdy, srok; logic e, qx, want;
    ops[0] = 2'b01; ops[1] = 2'b10; ops[2] = 2'b00;
    for (int i = 0; i < 3; i++) begin
      run_cmd(ops[i], 0, lat, rdy, srok, en_cyc, e, qx);
      want = (ops[i] == 2'b10) ? 1'b1 : (ops[i] == 2'b01) ? 1'b0 : model_q;
      model_q = want; last_qexp = want;
      checks++;
      if (!rdy || lat != LAT || e !== 1'b0 || qx !== want) begin
        fails++;
        $display("FAIL b2b_%0d: rdy=%0d lat=%0d err=%b q_exp=%b, required 1/%0d/0/%b", i, rdy, lat, e, qx, LAT, want);
      end
    end
  endtask

  task automatic test_reset_mid_pulse();
    bit seen_en, seen_done;
    seen_en = 0;
    seen_done = 0;
    cmd_valid = 1'b1;
    cmd_op = 2'b10;
    @(posedge clk);
    for (int k = 0; k < 10 && !seen_en; k++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      if (en === 1'b1) seen_en = 1;
    end
    checks++; if (!seen_en) begin fails++; $display("FAIL midrst_en_rise: en not seen within budget, required en=1"); end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({cmd_ready, s, r, en, done} !== 5'b10000) begin
      fails++;
      $display("FAIL midrst_outputs: {rdy,s,r,en,done}=%b, required 10000", {cmd_ready, s, r, en, done});
    end
    rst = 1'b0;
    model_q = 1'b1; last_qexp = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done !== 1'b0) seen_done = 1;
    end
    checks++; if (seen_done) begin fails++; $display("FAIL midrst_no_done: done seen after reset, required none"); end
  endtask

  task automatic test_random();
    int lat, en_cyc; bit rdy, srok, inj; logic e, qx, want_q, want_e;
    logic [1:0] op;
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      op  = 2'($urandom_range(0, 3));
      inj = (op != 2'b11) && ($urandom_range(0, 5) == 0);
      run_cmd(op, inj, lat, rdy, srok, en_cyc, e, qx);
      if (op == 2'b11) begin
        want_q = last_qexp;
        want_e = 1'b1;
      end else begin
        want_q = (op == 2'b10) ? 1'b1 : (op == 2'b01) ? 1'b0 : model_q;
        want_e = inj;
        model_q = want_q;
        last_qexp = want_q;
      end
      checks++;
      if (!rdy || lat != ((op == 2'b11) ? 1 : LAT) || en_cyc != ((op == 2'b11) ? 0 : P) || !srok
          || e !== want_e || qx !== want_q) begin
        fails++;
        $display("FAIL rand_%0d op=%b: rdy=%0d lat=%0d en=%0d sr_ok=%0d err=%b q_exp=%b, required err=%b q_exp=%b",
                 i, op, rdy, lat, en_cyc, srok, e, qx, want_e, want_q);
      end
    end
    checks++;
    if (q_in !== model_q) begin fails++; $display("FAIL rand_latch: q=%b, required %b", q_in, model_q); end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_op = 2'b00;
    model_q = 1'b0;
    last_qexp = 1'b0;
    test_reset();
    test_set();
    test_set_reset();
    test_set_hold();
    test_illegal();
    test_fault_check();
    test_back_to_back();
    test_reset_mid_pulse();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
